muldiv_seq: RTL

- Multi-cycle sequencer for unsigned multiply and divide (MIPS multu/divu). It owns the architectural HI/LO registers that the ALU reads for mfhi/mflo.
- It sits beside the main ALU. Decode pulses `start` with the R-type Funct and both register operands. The block iterates one bit per cycle, then commits HI/LO.
- It raises `stall` to hold the pipeline when an mfhi/mflo is decoded while a result is still pending.

---
 rtl/muldiv_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer owning the architectural HI/LO
// registers; one shift-add or restoring-divide step per clock, WIDTH steps per op.
module muldiv_seq #(
  parameter int          WIDTH   = 32,
  parameter logic [5:0]  F_MULTU = 6'd25,
  parameter logic [5:0]  F_DIVU  = 6'd27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_op;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_can_accept;
  logic               w_acc_mul;
  logic               w_acc_div;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shrem;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_p_step;

  // Accept decode, status outputs and pipeline stall request
  always_comb begin
    w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);
    w_acc_mul    = w_can_accept && start && (Funct == F_MULTU);
    w_acc_div    = w_can_accept && start && (Funct == F_DIVU);
    w_last       = (r_cnt == CW'(WIDTH - 1));
    busy         = (r_state == S_MUL) || (r_state == S_DIV);
    done         = (r_state == S_DONE);
    stall        = mf_req && (busy || w_acc_mul || w_acc_div);
    HI           = r_hi;
    LO           = r_lo;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_acc_mul) begin
          w_state_nxt = S_MUL;
        end else if (w_acc_div) begin
          w_state_nxt = S_DIV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration step: shift-add for MUL, restoring subtract for DIV
  always_comb begin
    w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_op} : {(WIDTH+1){1'b0}});
    // The shifted remainder needs one extra bit: it can reach 2*divisor-1
    w_shrem  = r_p[2*WIDTH-1:WIDTH-1];
    w_ge     = (w_shrem >= {1'b0, r_op});
    w_diff   = w_shrem[WIDTH-1:0] - r_op;
    w_p_step = {w_sum, r_p[WIDTH-1:1]};
    if (r_state == S_DIV) begin
      if (w_ge) begin
        w_p_step = {w_diff, r_p[WIDTH-2:0], 1'b1};
      end else begin
        w_p_step = {w_shrem[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_p_step = {w_sum, r_p[WIDTH-1:1]};
    end
  end

  // State, working registers and HI/LO commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_p     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc_mul) begin
        r_op  <= SrcA;
        r_p   <= {{WIDTH{1'b0}}, SrcB};
        r_cnt <= '0;
      end else if (w_acc_div) begin
        r_op  <= SrcB;
        r_p   <= {{WIDTH{1'b0}}, SrcA};
        r_cnt <= '0;
      end else if (busy) begin
        r_p   <= w_p_step;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_hi <= w_p_step[2*WIDTH-1:WIDTH];
          r_lo <= w_p_step[WIDTH-1:0];
        end
      end
    end
  end

endmodule
